// File: rtl/mem_access_ctrl_if.sv
// Bundle of the core request/response handshake and the 8-bit data memory port
// used by mem_access_ctrl. The controller connects through the slave modport;
// the core/memory side (or a bench) uses the master modport.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_wide;
  logic [ADDR_W-1:0]     req_addr;
  logic [2*DATA_W-1:0]   req_wdata;
  logic                  resp_valid;
  logic [2*DATA_W-1:0]   resp_rdata;
  logic                  resp_error;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_W-1:0]     mem_data_out;

  modport master (
    output req_valid, req_write, req_wide, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_write_data, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_wide, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for a byte-wide data memory.
// Byte requests take one memory access, wide (16-bit) requests are split into
// a low-byte access at addr and a high-byte access at addr+1 (little-endian,
// address wraps). One resp_valid pulse is returned per accepted request.
// Optional feature macro: ALIGN_CHECK_EN -- when defined, wide requests at an
// odd address are rejected without touching memory and flagged on resp_error.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic                write_q, write_d;
  logic                wide_q, wide_d;
`ifdef ALIGN_CHECK_EN
  logic                err_q, err_d;
`endif

  // Next-state and request/read-data capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    wide_d  = wide_q;
`ifdef ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          wide_d  = bus.req_wide;
          // Cleared on accept so stores and byte loads return zero upper bits
          rdata_d = '0;
          state_d = S_LO;
`ifdef ALIGN_CHECK_EN
          err_d   = 1'b0;
          if (bus.req_wide && bus.req_addr[0]) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_LO: begin
        if (!write_q) rdata_d[DATA_W-1:0] = bus.mem_data_out;
        state_d = wide_q ? S_HI : S_RESP;
      end
      S_HI: begin
        if (!write_q) rdata_d[2*DATA_W-1:DATA_W] = bus.mem_data_out;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: the only registers that see reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
`ifdef ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request and read-data holding registers; outputs are gated by state so no reset needed
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    write_q <= write_d;
    wide_q  <= wide_d;
  end

  // Output decode purely from registered state
  always_comb begin
    bus.req_ready      = (state_q == S_IDLE);
    bus.resp_valid     = (state_q == S_RESP);
    bus.resp_rdata     = (state_q == S_RESP) ? rdata_q : '0;
`ifdef ALIGN_CHECK_EN
    bus.resp_error     = (state_q == S_RESP) && err_q;
`else
    bus.resp_error     = 1'b0;
`endif
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    if (state_q == S_LO) begin
      bus.mem_addr       = addr_q;
      bus.mem_write      = write_q;
      bus.mem_read       = !write_q;
      bus.mem_write_data = write_q ? wdata_q[DATA_W-1:0] : '0;
    end else if (state_q == S_HI) begin
      bus.mem_addr       = addr_q + ADDR_W'(1);
      bus.mem_write      = write_q;
      bus.mem_read       = !write_q;
      bus.mem_write_data = write_q ? wdata_q[2*DATA_W-1:DATA_W] : '0;
    end
  end

endmodule
